// File: rtl/fifo_hdl_pkg.sv
// Shared helpers for the fifo width converters: port widths, length normalisation
// and the shift-entry update selector used by the splitter.
package fifo_hdl_pkg;

  function automatic int len_w(input int nsize);
    return $clog2(nsize + 1);
  endfunction

  function automatic int idx_w(input int nsize);
    return (nsize > 1) ? $clog2(nsize) : 1;
  endfunction

  // A length of zero or beyond the word size means "the whole word".
  function automatic int norm_len(input int len, input int nsize);
    return (len == 0 || len > nsize) ? nsize : len;
  endfunction

  typedef enum logic [2:0] {
    SH_KEEP,
    SH_SHIFT,
    SH_LOAD_HOLD,
    SH_LOAD_WRITE,
    SH_DRAIN
  } sh_op_t;

endpackage

// File: rtl/fifo_split_if.sv
// Wide-word write side and narrow-beat read side of the width splitter.
interface fifo_split_if #(
  parameter int DSIZE = 1,
  parameter int NSIZE = 8
);
  import fifo_hdl_pkg::*;

  localparam int LW = len_w(NSIZE);
  localparam int IW = idx_w(NSIZE);

  logic [DSIZE*NSIZE-1:0] wr_data;
  logic [LW-1:0]          wr_len;
  logic                   wr_vld;
  logic                   wr_ready;
  logic [DSIZE-1:0]       rd_data;
  logic [IW-1:0]          rd_idx;
  logic                   rd_last;
  logic                   rd_vld;
  logic                   rd_ready;

  modport master (
    output wr_data, wr_len, wr_vld, rd_ready,
    input  wr_ready, rd_data, rd_idx, rd_last, rd_vld
  );

  modport slave (
    input  wr_data, wr_len, wr_vld, rd_ready,
    output wr_ready, rd_data, rd_idx, rd_last, rd_vld
  );

endinterface

// File: rtl/fifo_split_hold.sv
// One-entry registered slice holding the next wide word while the shift entry is busy.
module fifo_split_hold #(
  parameter int DSIZE = 1,
  parameter int NSIZE = 8
) (
  input  logic                                 clock,
  input  logic                                 rst_n,
  input  logic [DSIZE*NSIZE-1:0]               in_data,
  input  logic [fifo_hdl_pkg::len_w(NSIZE)-1:0] in_len,
  input  logic                                 load,
  input  logic                                 unload,
  output logic [DSIZE*NSIZE-1:0]               data,
  output logic [fifo_hdl_pkg::len_w(NSIZE)-1:0] len,
  output logic                                 vld
);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      len  <= '0;
      vld  <= 1'b0;
    end else if (load) begin
      data <= in_data;
      len  <= in_len;
      vld  <= 1'b1;
    end else if (unload) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_split.sv
// Wide-to-narrow width splitter: each wide word is emitted MSB slice first as up to
// NSIZE beats, using a hold entry plus a shift entry for bubble-free streaming.
module fifo_split #(
  parameter int DSIZE = 1,
  parameter int NSIZE = 8
) (
  input logic         clock,
  input logic         rst_n,
  fifo_split_if.slave bus
);
  import fifo_hdl_pkg::*;

  localparam int WW = DSIZE * NSIZE;
  localparam int LW = len_w(NSIZE);
  localparam int IW = idx_w(NSIZE);

  logic [WW-1:0] sh_data;
  logic [LW-1:0] sh_rem;
  logic [IW-1:0] sh_idx;
  logic          sh_vld;

  logic [WW-1:0] hold_data;
  logic [LW-1:0] hold_len;
  logic          hold_vld;

  logic          wr_ready_q;
  logic [LW-1:0] wr_len_n;
  logic          wr_hs;
  logic          rd_hs;
  logic          rd_last;
  logic          sh_free;
  logic          hold_load;
  logic          hold_unload;
  logic          hold_vld_next;
  sh_op_t        sh_op;

  assign wr_len_n = LW'(norm_len(int'(bus.wr_len), NSIZE));

  assign wr_hs   = bus.wr_vld && wr_ready_q;
  assign rd_last = (sh_rem == LW'(1));
  assign rd_hs   = sh_vld && bus.rd_ready;
  assign sh_free = !sh_vld || (rd_hs && rd_last);

  // The hold entry only takes a write when the shift entry cannot accept it directly.
  assign hold_unload   = sh_free && hold_vld;
  assign hold_load     = wr_hs && !(sh_free && !hold_vld);
  assign hold_vld_next = hold_load || (hold_vld && !hold_unload);

  fifo_split_hold #(
    .DSIZE (DSIZE),
    .NSIZE (NSIZE)
  ) u_hold (
    .clock   (clock),
    .rst_n   (rst_n),
    .in_data (bus.wr_data),
    .in_len  (wr_len_n),
    .load    (hold_load),
    .unload  (hold_unload),
    .data    (hold_data),
    .len     (hold_len),
    .vld     (hold_vld)
  );

  always_comb begin
    sh_op = SH_KEEP;
    if (sh_free) begin
      if (hold_vld)
        sh_op = SH_LOAD_HOLD;
      else if (wr_hs)
        sh_op = SH_LOAD_WRITE;
      else
        sh_op = SH_DRAIN;
    end else if (rd_hs) begin
      sh_op = SH_SHIFT;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sh_data <= '0;
      sh_rem  <= '0;
      sh_idx  <= '0;
      sh_vld  <= 1'b0;
    end else begin
      unique case (sh_op)
        SH_SHIFT: begin
          sh_data <= {sh_data[WW-DSIZE-1:0], {DSIZE{1'b0}}};
          sh_rem  <= sh_rem - LW'(1);
          sh_idx  <= sh_idx + IW'(1);
        end
        SH_LOAD_HOLD: begin
          sh_data <= hold_data;
          sh_rem  <= hold_len;
          sh_idx  <= '0;
          sh_vld  <= 1'b1;
        end
        SH_LOAD_WRITE: begin
          sh_data <= bus.wr_data;
          sh_rem  <= wr_len_n;
          sh_idx  <= '0;
          sh_vld  <= 1'b1;
        end
        SH_DRAIN: begin
          sh_data <= '0;
          sh_rem  <= '0;
          sh_idx  <= '0;
          sh_vld  <= 1'b0;
        end
        SH_KEEP: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Registered from the next hold state so rd_ready never reaches wr_ready combinationally.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      wr_ready_q <= 1'b0;
    else
      wr_ready_q <= !hold_vld_next;
  end

  assign bus.wr_ready = wr_ready_q;
  assign bus.rd_vld   = sh_vld;
  assign bus.rd_data  = sh_data[WW-1 -: DSIZE];
  assign bus.rd_idx   = sh_idx;
  assign bus.rd_last  = rd_last;

  a_hold_no_overwrite: assert property (
    @(posedge clock) disable iff (!rst_n) hold_load |-> !hold_vld
  );

  a_rd_stable_on_stall: assert property (
    @(posedge clock) disable iff (!rst_n)
      (sh_vld && !bus.rd_ready) |=> (sh_vld && $stable(sh_data) && $stable(sh_idx) && $stable(sh_rem))
  );

endmodule

// File: tb/tb_fifo_split.sv
// Self-checking bench for fifo_split (DSIZE=4, NSIZE=4): directed vector table,
// reset corner sequences and random traffic against a beat-queue reference model.
module tb_fifo_split;

  localparam int DSIZE = 4;
  localparam int NSIZE = 4;

  logic clock = 1'b0;
  logic rst_n;

  fifo_split_if #(.DSIZE(DSIZE), .NSIZE(NSIZE)) bus ();

  fifo_split #(
    .DSIZE (DSIZE),
    .NSIZE (NSIZE)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] data;
    int         idx;
    logic       last;
  } beat_t;

  typedef struct {
    logic [15:0] wd;
    logic [2:0]  wl;
    logic        wv;
    logic        rr;
    logic        e_vld;
    logic [3:0]  e_data;
    logic [1:0]  e_idx;
    logic        e_last;
    logic        e_ready;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[$];
  bit    armed;
  int    n_checks;
  int    n_fail;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int wordsPending();
    int words = 0;
    foreach (exp_q[i])
      if (exp_q[i].last) words++;
    return words;
  endfunction

  // Every accepted wide word becomes its list of narrow beats, MSB nibble first.
  task automatic pushWord(input logic [15:0] wd, input logic [2:0] wl);
    int len;
    beat_t b;
    len = (wl == 3'd0 || int'(wl) > NSIZE) ? NSIZE : int'(wl);
    for (int k = 0; k < len; k++) begin
      b.data = 4'((wd >> (DSIZE * (NSIZE - 1 - k))) & 16'hF);
      b.idx  = k;
      b.last = (k == len - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic modelCheck(input string tag);
    int words;
    words = wordsPending();
    checkOutput({tag, " rd_vld"}, 32'(bus.rd_vld), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      checkOutput({tag, " rd_data"}, 32'(bus.rd_data), 32'(exp_q[0].data));
      checkOutput({tag, " rd_idx"}, 32'(bus.rd_idx), 32'(exp_q[0].idx));
      checkOutput({tag, " rd_last"}, 32'(bus.rd_last), 32'(exp_q[0].last));
    end
    checkOutput({tag, " wr_ready"}, 32'(bus.wr_ready), 32'(armed && words < 2));
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the rising
  // edge from its own view of both handshakes, then compare at the next falling edge.
  task automatic applyStimulus(input logic [15:0] wd, input logic [2:0] wl, input logic wv, input logic rr);
    bit wr_hs;
    bit rd_hs;
    bus.wr_data  = wd;
    bus.wr_len   = wl;
    bus.wr_vld   = wv;
    bus.rd_ready = rr;
    wr_hs = wv && armed && (wordsPending() < 2);
    rd_hs = rr && (exp_q.size() != 0);
    @(posedge clock);
    if (rst_n) begin
      if (rd_hs) void'(exp_q.pop_front());
      if (wr_hs) pushWord(wd, wl);
      armed = 1'b1;
    end
    @(negedge clock);
    modelCheck("model");
  endtask

  task automatic addVec(input logic [15:0] wd, input logic [2:0] wl, input logic wv, input logic rr,
                        input logic ev, input logic [3:0] ed, input logic [1:0] ei, input logic el,
                        input logic er);
    vec_t v;
    v.wd = wd; v.wl = wl; v.wv = wv; v.rr = rr;
    v.e_vld = ev; v.e_data = ed; v.e_idx = ei; v.e_last = el; v.e_ready = er;
    vecs.push_back(v);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    armed    = 1'b0;
    rst_n    = 1'b0;
    bus.wr_data  = '0;
    bus.wr_len   = '0;
    bus.wr_vld   = 1'b0;
    bus.rd_ready = 1'b0;

    // Word streams: ABCD; back-to-back 1234/5678; len 2 then len 0; len-1 bypass; stall.
    addVec(16'hABCD, 3'd4, 1'b1, 1'b1, 1'b1, 4'hA, 2'd0, 1'b0, 1'b1);
    addVec(16'h1234, 3'd4, 1'b1, 1'b1, 1'b1, 4'hB, 2'd1, 1'b0, 1'b0);
    addVec(16'h5678, 3'd4, 1'b1, 1'b1, 1'b1, 4'hC, 2'd2, 1'b0, 1'b0);
    addVec(16'h5678, 3'd4, 1'b1, 1'b1, 1'b1, 4'hD, 2'd3, 1'b1, 1'b0);
    addVec(16'h5678, 3'd4, 1'b1, 1'b1, 1'b1, 4'h1, 2'd0, 1'b0, 1'b1);
    addVec(16'h5678, 3'd4, 1'b1, 1'b1, 1'b1, 4'h2, 2'd1, 1'b0, 1'b0);
    addVec(16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 4'h3, 2'd2, 1'b0, 1'b0);
    addVec(16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 4'h4, 2'd3, 1'b1, 1'b0);
    addVec(16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 4'h5, 2'd0, 1'b0, 1'b1);
    addVec(16'h9ABC, 3'd2, 1'b1, 1'b1, 1'b1, 4'h6, 2'd1, 1'b0, 1'b0);
    addVec(16'hDEF0, 3'd0, 1'b1, 1'b1, 1'b1, 4'h7, 2'd2, 1'b0, 1'b0);
    addVec(16'hDEF0, 3'd0, 1'b1, 1'b1, 1'b1, 4'h8, 2'd3, 1'b1, 1'b0);
    addVec(16'hDEF0, 3'd0, 1'b1, 1'b1, 1'b1, 4'h9, 2'd0, 1'b0, 1'b1);
    addVec(16'hDEF0, 3'd0, 1'b1, 1'b1, 1'b1, 4'hA, 2'd1, 1'b1, 1'b0);
    addVec(16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 4'hD, 2'd0, 1'b0, 1'b1);
    addVec(16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 4'hE, 2'd1, 1'b0, 1'b1);
    addVec(16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 4'hF, 2'd2, 1'b0, 1'b1);
    addVec(16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 4'h0, 2'd3, 1'b1, 1'b1);
    addVec(16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1);
    addVec(16'h7000, 3'd1, 1'b1, 1'b1, 1'b1, 4'h7, 2'd0, 1'b1, 1'b1);
    addVec(16'h8000, 3'd1, 1'b1, 1'b1, 1'b1, 4'h8, 2'd0, 1'b1, 1'b1);
    addVec(16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1);
    addVec(16'h1357, 3'd4, 1'b1, 1'b1, 1'b1, 4'h1, 2'd0, 1'b0, 1'b1);
    addVec(16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 4'h3, 2'd1, 1'b0, 1'b1);
    addVec(16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 4'h3, 2'd1, 1'b0, 1'b1);
    addVec(16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 4'h3, 2'd1, 1'b0, 1'b1);
    addVec(16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 4'h3, 2'd1, 1'b0, 1'b1);
    addVec(16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 4'h5, 2'd2, 1'b0, 1'b1);
    addVec(16'h0000, 3'd0, 1'b0, 1'b1, 1'b1, 4'h7, 2'd3, 1'b1, 1'b1);
    addVec(16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1);

    $display("[TB] reset phase");
    #1;
    checkOutput("reset wr_ready", 32'(bus.wr_ready), 32'd0);
    checkOutput("reset rd_vld", 32'(bus.rd_vld), 32'd0);
    checkOutput("reset rd_last", 32'(bus.rd_last), 32'd0);
    checkOutput("reset rd_data", 32'(bus.rd_data), 32'd0);
    checkOutput("reset rd_idx", 32'(bus.rd_idx), 32'd0);
    @(negedge clock);
    applyStimulus(16'h0000, 3'd0, 1'b0, 1'b1);
    applyStimulus(16'h0000, 3'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    applyStimulus(16'h0000, 3'd0, 1'b0, 1'b1);
    checkOutput("release wr_ready", 32'(bus.wr_ready), 32'd1);
    checkOutput("release rd_vld", 32'(bus.rd_vld), 32'd0);

    $display("[TB] vector table phase");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wd, vecs[i].wl, vecs[i].wv, vecs[i].rr);
      checkOutput($sformatf("vec%0d rd_vld", i), 32'(bus.rd_vld), 32'(vecs[i].e_vld));
      checkOutput($sformatf("vec%0d wr_ready", i), 32'(bus.wr_ready), 32'(vecs[i].e_ready));
      if (vecs[i].e_vld) begin
        checkOutput($sformatf("vec%0d rd_data", i), 32'(bus.rd_data), 32'(vecs[i].e_data));
        checkOutput($sformatf("vec%0d rd_idx", i), 32'(bus.rd_idx), 32'(vecs[i].e_idx));
        checkOutput($sformatf("vec%0d rd_last", i), 32'(bus.rd_last), 32'(vecs[i].e_last));
      end
    end

    $display("[TB] mid-word reset phase");
    applyStimulus(16'h2468, 3'd4, 1'b1, 1'b1);
    applyStimulus(16'h0000, 3'd0, 1'b0, 1'b1);
    checkOutput("pre-reset rd_data", 32'(bus.rd_data), 32'h4);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    armed = 1'b0;
    #1;
    checkOutput("async reset rd_vld", 32'(bus.rd_vld), 32'd0);
    checkOutput("async reset wr_ready", 32'(bus.wr_ready), 32'd0);
    checkOutput("async reset rd_last", 32'(bus.rd_last), 32'd0);
    checkOutput("async reset rd_data", 32'(bus.rd_data), 32'd0);
    @(negedge clock);
    applyStimulus(16'h0000, 3'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    applyStimulus(16'h0000, 3'd0, 1'b0, 1'b1);
    checkOutput("post-reset rd_vld", 32'(bus.rd_vld), 32'd0);
    applyStimulus(16'hFFFF, 3'd4, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("FFFF beat%0d rd_data", k), 32'(bus.rd_data), 32'hF);
      checkOutput($sformatf("FFFF beat%0d rd_idx", k), 32'(bus.rd_idx), 32'(k));
      checkOutput($sformatf("FFFF beat%0d rd_last", k), 32'(bus.rd_last), 32'(k == 3));
      applyStimulus(16'h0000, 3'd0, 1'b0, 1'b1);
    end
    checkOutput("FFFF drained rd_vld", 32'(bus.rd_vld), 32'd0);

    $display("[TB] random phase");
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(16'($urandom), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_split.md
# fifo_split

Width splitter, the read-side counterpart of the narrow-to-wide combiner. It accepts one wide word of NSIZE×DSIZE bits per valid/ready handshake and emits it as up to NSIZE narrow DSIZE-bit beats, MSB slice first. The final beat of each wide word is flagged with rd_last, which is the mirror of the combiner's align-last input. A two-entry buffer, one holding register plus one shift register, sustains one narrow beat per cycle with no bubbles between consecutive wide words.

## Interface
- DSIZE, 1, width of one narrow beat in bits
- NSIZE, 8, narrow beats per wide word (≥2)
- clock  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- wr_data  in  DSIZE*NSIZE  wide word; bits [DSIZE*NSIZE-1 -: DSIZE] are beat 0
- wr_len  in  LW=$clog2(NSIZE+1)  number of valid beats, 1..NSIZE; 0 or >NSIZE is treated as NSIZE
- wr_vld  in  1  wide word valid
- wr_ready  out  1  registered; wide word accepted when wr_vld && wr_ready
- rd_data  out  DSIZE  current narrow beat
- rd_idx  out  IW=$clog2(NSIZE)  index of current beat within its wide word
- rd_last  out  1  current beat is the final beat of its wide word
- rd_vld  out  1  narrow beat valid
- rd_ready  in  1  beat consumed when rd_vld && rd_ready

## Operation
- State: hold entry (hold_data, hold_len, hold_vld) and shift entry (sh_data, sh_rem, sh_idx, sh_vld).
- rd_vld = sh_vld. rd_data = top DSIZE bits of sh_data. rd_last = (sh_rem == 1). rd_idx = sh_idx.
- On a read handshake with rd_last=0: sh_data shifts left by DSIZE with zero fill, sh_rem decrements, sh_idx increments.
- sh_free = !sh_vld || (rd_vld && rd_ready && rd_last).
- When sh_free && hold_vld: load the hold entry into the shift entry, clear hold_vld, set sh_idx=0.
- When sh_free && !hold_vld && write handshake: load the write directly into the shift entry (bypass).
- When a write handshake occurs and the bypass condition does not hold: the write goes into the hold entry.
- When sh_free and nothing is available: clear sh_vld.
- wr_ready next-state = !hold_vld_next. A write can never overwrite an occupied hold entry.
- wr_len is normalised on entry: 0 or >NSIZE becomes NSIZE. sh_rem has width LW.
- Simultaneous final read and write with hold empty: the write bypasses into the shift entry. The next beat appears the following cycle with no bubble.
- rd_ready low: rd_data, rd_idx, rd_last and rd_vld stay stable (AXI-style; rd_vld never drops without a handshake).
- No combinational path exists from wr_* to rd_* or from rd_ready to wr_ready.

## Timing
- Reset (async assert): wr_ready=0, rd_vld=0, rd_last=0, rd_data=0, rd_idx=0, hold_vld=0, sh_rem=0.
- First rising edge after rst_n deasserts: wr_ready becomes 1.
- Latency: wide word accepted at edge N gives beat 0 with rd_vld=1 after edge N.
- Throughput: one beat per cycle while rd_ready=1. A wide word of len L occupies L cycles.
- wr_ready drops the cycle after the hold entry fills. It rises the cycle after hold moves to shift.
- Reset asserted mid-word: all in-flight beats are discarded and outputs take their reset values immediately.

## Structure
- Shared package fifo_hdl_pkg holds the width helper functions (len_w(NSIZE), idx_w(NSIZE)) and the normalisation function norm_len(). The combiner reuses these.
- One sub-module, fifo_split_hold: a one-entry registered slice for the hold entry, with inputs {data, len}, load, unload and output vld. Control logic and the shift entry stay in fifo_split.

## Test plan (DSIZE=4, NSIZE=4)
- Reset, then release rst_n → rd_vld=0 throughout; wr_ready=0 during reset and 1 from the first edge after release.
- wr_data=16'hABCD, wr_len=4, rd_ready=1 → beats A,B,C,D on the 4 cycles after acceptance; rd_idx=0..3; rd_last only on D.
- Back-to-back 16'h1234, 16'h5678, rd_ready=1 → 8 consecutive beats 1..8 with no gap; wr_ready low from the cycle after the second write until the cycle after beat 4.
- 16'h9ABC with wr_len=2, then 16'hDEF0 with wr_len=0 → beats 9, A(last), then D, E, F, 0(last).
- 16'h1357, rd_ready low for 3 cycles while beat 3 is shown → rd_data=3, rd_idx=1, rd_vld=1 held stable; beats resume 3, 5, 7 once rd_ready returns.
- rst_n pulsed low during beat 2 of 16'h2468 → rd_vld=0 at once; after release no stale beats appear and the next word 16'hFFFF emits F,F,F,F.
